key_schedule: RTL and testbench

- Drives the existing single-round `key_expansion` block iteratively to build the full AES-128 key schedule: round keys 0..NUM_ROUNDS.
- Generates the Rcon sequence and feeds each round's result back as the next input.
- Stores all round keys in a local register file.
- Sits between the key-load interface and the cipher round datapath, which reads round keys by index.

---
 rtl/aes_pkg.sv | 55 +++++
 rtl/key_schedule_if.sv | 24 ++
 rtl/key_expansion.sv | 76 +++++++
 rtl/key_schedule.sv | 103 ++++++++++
 tb/tb_key_schedule.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared types and GF(2^8) helpers.
// Key matrices are row-major unless a name says otherwise.
package aes_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [127:0] round_key_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Swaps row-major and column-major byte order; self-inverse.
  function automatic round_key_t transpose(input round_key_t k);
    round_key_t t;
    t = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[127-8*(4*c+r) -: 8] = k[127-8*(4*r+c) -: 8];
      end
    end
    return t;
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] v;
    sq = a;
    v  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      v  = gf_mul(v, sq);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/key_schedule_if.sv
// Key-load and round-key read bundle between host,
// key schedule and the cipher datapath.
interface key_schedule_if;
  import aes_pkg::*;

  logic       start_in;
  round_key_t key_in;
  logic       ready_out;
  logic       done_out;
  logic       keys_valid_out;
  logic [3:0] rk_addr_in;
  round_key_t rk_data_out;

  modport master (
    output start_in, key_in, rk_addr_in,
    input  ready_out, done_out, keys_valid_out, rk_data_out
  );

  modport slave (
    input  start_in, key_in, rk_addr_in,
    output ready_out, done_out, keys_valid_out, rk_data_out
  );

endinterface

// File: rtl/key_expansion.sv
// One AES-128 key expansion round, sub-word through a
// single shared S-box one byte per cycle.
module key_expansion
  import aes_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        new_key_in,
  input  round_key_t  key_in,
  input  logic [31:0] rcon_in,
  output logic        valid_out,
  output round_key_t  expanded_key_out
);

  localparam logic [1:0] KEY_WAIT = 2'd0;
  localparam logic [1:0] SUB      = 2'd1;
  localparam logic [1:0] MIX      = 2'd2;

  logic [1:0]  state;
  logic [1:0]  idx;
  round_key_t  cols;
  round_key_t  kc;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] rcon;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    kc = transpose(key_in);
    t  = sub ^ rcon;
    n0 = cols[127:96] ^ t;
    n1 = n0 ^ cols[95:64];
    n2 = n1 ^ cols[63:32];
    n3 = n2 ^ cols[31:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= KEY_WAIT;
      idx              <= 2'd0;
      cols             <= '0;
      rot              <= '0;
      sub              <= '0;
      rcon             <= '0;
      valid_out        <= 1'b0;
      expanded_key_out <= '0;
    end else begin
      valid_out <= 1'b0;
      unique case (1'b1)
        (state == KEY_WAIT): begin
          if (new_key_in) begin
            cols  <= kc;
            rot   <= {kc[23:0], kc[31:24]};
            rcon  <= rcon_in;
            idx   <= 2'd0;
            state <= SUB;
          end
        end
        (state == SUB): begin
          sub <= {sub[23:0], sbox(rot[31:24])};
          rot <= {rot[23:0], 8'h00};
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= MIX;
        end
        (state == MIX): begin
          expanded_key_out <= transpose({n0, n1, n2, n3});
          valid_out        <= 1'b1;
          state            <= KEY_WAIT;
        end
        default: state <= KEY_WAIT;
      endcase
    end
  end

endmodule

// File: rtl/key_schedule.sv
// Iterates key_expansion to build and hold the full
// AES-128 schedule, readable by round index.
module key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input logic          clk_in,
  input logic          rst_in,
  key_schedule_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_EXP = 2'd2;
  localparam logic [3:0] LAST     = 4'(NUM_ROUNDS);

  logic [1:0] state;
  logic [3:0] round;
  logic [7:0] rc;
  round_key_t cur_key;
  logic       done;
  logic       keys_valid;
  round_key_t rk_data;
  logic       new_key;
  logic       exp_valid;
  round_key_t exp_key;
  logic       load;
  logic       store;

  round_key_t rf [NUM_ROUNDS+1];

  assign new_key = (state == ISSUE);
  assign load    = (state == IDLE) && bus.start_in;
  assign store   = (state == WAIT_EXP) && exp_valid;

  assign bus.ready_out      = (state == IDLE);
  assign bus.done_out       = done;
  assign bus.keys_valid_out = keys_valid;
  assign bus.rk_data_out    = rk_data;

  key_expansion u_exp (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .new_key_in       (new_key),
    .key_in           (cur_key),
    .rcon_in          ({rc, 24'h0}),
    .valid_out        (exp_valid),
    .expanded_key_out (exp_key)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      round      <= 4'd0;
      rc         <= RCON_INIT;
      cur_key    <= '0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      rk_data    <= '0;
    end else begin
      done    <= 1'b0;
      rk_data <= (bus.rk_addr_in <= LAST) ?
                 rf[bus.rk_addr_in] : '0;
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.start_in) begin
            cur_key    <= bus.key_in;
            rc         <= RCON_INIT;
            round      <= 4'd1;
            keys_valid <= 1'b0;
            state      <= ISSUE;
          end
        end
        (state == ISSUE): state <= WAIT_EXP;
        (state == WAIT_EXP): begin
          if (exp_valid) begin
            cur_key <= exp_key;
            rc      <= xtime(rc);
            if (round == LAST) begin
              done       <= 1'b1;
              keys_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              round <= round + 4'd1;
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; readers gate on keys_valid.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (load) rf[0] <= bus.key_in;
      else if (store) rf[round] <= exp_key;
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule with FIPS-197 and
// all-zero key vectors.
module tb_key_schedule;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_schedule_if bus ();

  key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  int   nk_cnt   = 0;
  int   done_cnt = 0;
  int   wide     = 0;
  logic nk_prev  = 1'b0;
  logic [7:0] rc_log [128];

  localparam logic [127:0] FIPS_K  =
    128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_1  =
    128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_10 =
    128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_1  =
    128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] ZERO_10 =
    128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  logic [7:0] rc_exp [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Column words (w0 in the MSBs) to row-major bytes.
  function automatic logic [127:0] rm(input logic [127:0] cm);
    logic [127:0] r;
    r = '0;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) begin
        r[127-8*(4*b+w) -: 8] = cm[127-32*w-8*b -: 8];
      end
    end
    return r;
  endfunction

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dut.u_exp.new_key_in) begin
      if (nk_prev) wide++;
      if (nk_cnt < 128) rc_log[nk_cnt] = dut.u_exp.rcon_in[31:24];
      nk_cnt++;
    end
    nk_prev = dut.u_exp.new_key_in;
    if (bus.done_out) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input logic [127:0] k);
    bus.key_in   = k;
    bus.start_in = 1'b1;
    @(negedge clk);
    bus.start_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bus.done_out && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(bus.done_out), 128'(1));
  endtask

  task automatic wait_nk(input string tag, input int target);
    int seen;
    int n;
    seen = dut.u_exp.new_key_in ? 1 : 0;
    n = 0;
    while (seen < target && n < 1000) begin
      @(negedge clk);
      n++;
      if (dut.u_exp.new_key_in) seen++;
    end
    check(tag, 128'(seen), 128'(target));
  endtask

  task automatic rd(input logic [3:0] a, output logic [127:0] d);
    bus.rk_addr_in = a;
    @(negedge clk);
    d = bus.rk_data_out;
  endtask

  logic [127:0] d;
  int nk0;
  int d0;

  initial begin
    bus.start_in   = 1'b0;
    bus.key_in     = '0;
    bus.rk_addr_in = 4'd0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_ready", 128'(bus.ready_out), 128'(1));
    check("rst_done", 128'(bus.done_out), 128'(0));
    check("rst_kv", 128'(bus.keys_valid_out), 128'(0));
    check("rst_rk", bus.rk_data_out, 128'(0));
    rst = 1'b0;
    tick();

    nk0 = nk_cnt;
    d0  = done_cnt;
    go(rm(FIPS_K));
    check("busy_ready", 128'(bus.ready_out), 128'(0));
    check("busy_kv", 128'(bus.keys_valid_out), 128'(0));
    wait_done("fips_done");
    check("fips_kv_edge", 128'(bus.keys_valid_out), 128'(1));
    tick();
    check("fips_ready", 128'(bus.ready_out), 128'(1));
    check("fips_done_width", 128'(bus.done_out), 128'(0));
    repeat (5) tick();
    check("fips_done_cnt", 128'(done_cnt - d0), 128'(1));
    check("fips_nk_cnt", 128'(nk_cnt - nk0), 128'(10));
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rcon%0d", i),
            128'(rc_log[nk0+i]), 128'(rc_exp[i]));
    end
    rd(4'd0, d);
    check("fips_rk0", d, rm(FIPS_K));
    rd(4'd1, d);
    check("fips_rk1", d, rm(FIPS_1));
    rd(4'd10, d);
    check("fips_rk10", d, rm(FIPS_10));

    go(128'h0);
    wait_done("zero_done");
    tick();
    rd(4'd1, d);
    check("zero_rk1", d, rm(ZERO_1));
    rd(4'd10, d);
    check("zero_rk10", d, rm(ZERO_10));
    for (int a = 11; a < 16; a++) begin
      rd(4'(a), d);
      check($sformatf("oob%0d", a), d, 128'(0));
    end

    d0 = done_cnt;
    go(rm(FIPS_K));
    wait_nk("mid_r4", 4);
    tick();
    go(128'h0);
    wait_done("mid_done");
    repeat (100) tick();
    check("mid_done_cnt", 128'(done_cnt - d0), 128'(1));
    rd(4'd0, d);
    check("mid_rk0", d, rm(FIPS_K));
    rd(4'd10, d);
    check("mid_rk10", d, rm(FIPS_10));

    d0 = done_cnt;
    go(128'h0);
    wait_nk("rst_r6", 6);
    tick();
    rst = 1'b1;
    tick();
    check("abort_ready", 128'(bus.ready_out), 128'(1));
    check("abort_kv", 128'(bus.keys_valid_out), 128'(0));
    rst = 1'b0;
    repeat (100) tick();
    check("abort_no_done", 128'(done_cnt - d0), 128'(0));
    go(rm(FIPS_K));
    wait_done("fresh_done");
    tick();
    rd(4'd1, d);
    check("fresh_rk1", d, rm(FIPS_1));
    rd(4'd10, d);
    check("fresh_rk10", d, rm(FIPS_10));

    go(128'h0);
    wait_done("b2b_first");
    tick();
    go(rm(FIPS_K));
    check("b2b_kv_drop", 128'(bus.keys_valid_out), 128'(0));
    check("b2b_busy", 128'(bus.ready_out), 128'(0));
    wait_done("b2b_second");
    check("b2b_kv_rise", 128'(bus.keys_valid_out), 128'(1));
    tick();
    rd(4'd0, d);
    check("b2b_rk0", d, rm(FIPS_K));
    rd(4'd1, d);
    check("b2b_rk1", d, rm(FIPS_1));
    rd(4'd10, d);
    check("b2b_rk10", d, rm(FIPS_10));

    check("nk_width", 128'(wide), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
